uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL expose parameter CLKS_PER_BIT, default 868, meaning clock cycles per UART bit period; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 tx_start  input  1  frame request; sampled every cycle.
REQ-005 tx_data  input  8  byte to send; SHALL only need to be valid in the cycle tx_start is accepted.
REQ-006 piso_in  input  1  serial bit from the downstream 8-bit shift register (its LSB).
REQ-007 piso_load  output  1  load strobe to the shift register.
REQ-008 piso_shift  output  1  right-shift strobe to the shift register.
REQ-009 piso_data  output  8  parallel byte to the shift register.
REQ-010 tx  output  1  UART serial line, idle high.
REQ-011 tx_busy  output  1  high whenever the state is not IDLE.
REQ-012 tx_done  output  1  one-cycle pulse at end of a frame.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-014 Baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1 in every non-IDLE state, wrap to 0 at terminal count, and be held at 0 in IDLE.
REQ-015 Accept condition: state==IDLE and tx_start==1.
  - piso_load SHALL be combinationally high in that cycle only.
  - piso_data SHALL equal tx_data combinationally.
  - state SHALL move to START on the same edge.
REQ-016 tx SHALL be a state-decoded mux:
  - IDLE: 1
  - START: 0
  - DATA: piso_in
  - PARITY: parity register
  - STOP: 1
REQ-017 Each non-IDLE state SHALL last exactly CLKS_PER_BIT cycles, then advance:
  - START -> DATA
  - DATA -> DATA until the 8th bit, then PARITY (macro on) or STOP
  - PARITY -> STOP
  - STOP -> IDLE
REQ-018 piso_shift SHALL equal (state==DATA and baud counter at terminal count); exactly 8 pulses per frame.
REQ-019 A 3-bit bit counter SHALL clear on entry to DATA, increment on each piso_shift, and leave DATA when its value is 7 at terminal count.
REQ-020 Data SHALL leave LSB first.
REQ-021 tx_done SHALL be registered and high for exactly the one cycle following the STOP terminal-count edge; the state is IDLE in that cycle.
REQ-022 tx_start while busy SHALL be ignored, with no queuing and no effect on the frame in progress.
REQ-023 With tx_start held high, the next frame SHALL be accepted in the first IDLE cycle, giving a gap of exactly one idle-high cycle between frames.
REQ-024 Frame length, accept edge to the tx_done edge, SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).

Reset
REQ-025 While reset is low the block SHALL immediately hold: state IDLE; tx=1; tx_busy=0; tx_done=0; piso_load=0; piso_shift=0; baud counter, bit counter and parity register at 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no tx_done.
REQ-027 After reset release the block SHALL accept a new frame on the first clock with tx_start=1.

Configuration
REQ-028 Macro UART_TX_PARITY_EN defined:
  - Parity register SHALL load the XOR of tx_data (even parity) at accept.
  - The PARITY state SHALL be inserted between DATA and STOP.
REQ-029 Macro UART_TX_PARITY_EN undefined: no PARITY state and no parity register SHALL exist, and DATA SHALL go directly to STOP.

Verification (CLKS_PER_BIT=4)
REQ-030 Accept 0x55 -> tx = 0 for 4 cycles, then 1,0,1,0,1,0,1,0 each for 4 cycles, then 1 for 4 cycles; tx_done single pulse 40 cycles after accept; 1 piso_load and 8 piso_shift pulses.
REQ-031 Pulse tx_start with 0xFF at cycle 10 of a frame carrying 0x00 -> frame carries 0x00 unchanged; no second frame starts.
REQ-032 Hold tx_start high with 0xA3 -> back-to-back frames, each 40 cycles, separated by exactly 1 idle-high cycle.
REQ-033 Pull reset low during the 3rd data bit -> tx=1 and tx_busy=0 within the same cycle, no tx_done; after release a 0x0F frame is transmitted correctly.
REQ-034 UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 after the data bits; frame 44 cycles. Send 0x03 -> parity bit 0.
REQ-035 Assert tx_start in the tx_done cycle -> accepted immediately; piso_load high in that same cycle.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//   UART transmit sequencer for an external 8-bit PISO shift register. On a
//   request it loads the byte into the shift register. It then drives the
//   start bit, the eight data bits (LSB first, taken from piso_in), an optional
//   even-parity bit, and the stop bit. Each bit lasts CLKS_PER_BIT cycles.
//
//   Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state and the
//   even-parity register). The default build has no parity bit.
//
//   Ports
//     clk         sole clock, rising edge
//     reset       asynchronous reset, active low
//     tx_start    frame request, sampled every cycle
//     tx_data     byte to send, only needed in the accept cycle
//     piso_in     serial bit from the shift register (its LSB)
//     piso_load   load strobe to the shift register (accept cycle only)
//     piso_shift  right-shift strobe at the end of every data bit
//     piso_data   parallel byte to the shift register (= tx_data)
//     tx          UART line, idle high
//     tx_busy     high whenever the FSM is not IDLE
//     tx_done     one-cycle pulse in the cycle after the stop bit ends
//
//   state  | meaning
//   IDLE   | line high, waiting for tx_start
//   START  | start bit (0)
//   DATA   | eight data bits, shifted out of the PISO
//   PARITY | even-parity bit (UART_TX_PARITY_EN only)
//   STOP   | stop bit (1)
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       piso_in,
  output logic       piso_load,
  output logic       piso_shift,
  output logic [7:0] piso_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_TC = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic          baud_tc;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  assign baud_tc = (baud_cnt == BAUD_TC);

  // The reset term keeps piso_load low while reset is held, even with
  // tx_start already high.
  assign piso_load  = reset && (state == IDLE) && tx_start;
  assign piso_data  = tx_data;
  assign piso_shift = (state == DATA) && baud_tc;
  assign tx_busy    = (state != IDLE);

  always_comb begin
    tx = 1'b1;
    case (state)
      IDLE:   tx = 1'b1;
      START:  tx = 1'b0;
      DATA:   tx = piso_in;
`ifdef UART_TX_PARITY_EN
      PARITY: tx = parity_bit;
`endif
      STOP:   tx = 1'b1;
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;

      if (state == IDLE || baud_tc) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (tx_start) begin
            state <= START;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_data;
`endif
          end
        end
        START: begin
          if (baud_tc) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (baud_tc) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tc) state <= STOP;
        end
`endif
        STOP: begin
          if (baud_tc) begin
            state   <= IDLE;
            tx_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       piso_in;
  logic       piso_load, piso_shift, tx, tx_busy, tx_done;
  logic [7:0] piso_data;

  uart_tx_ctrl #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .piso_in(piso_in), .piso_load(piso_load), .piso_shift(piso_shift),
    .piso_data(piso_data), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // downstream shift register
  logic [7:0] piso_reg;
  always @(posedge clk or negedge reset) begin
    if (!reset)          piso_reg <= 8'h00;
    else if (piso_load)  piso_reg <= piso_data;
    else if (piso_shift) piso_reg <= {1'b0, piso_reg[7:1]};
  end
  assign piso_in = piso_reg[0];

  typedef struct packed {
    logic       par;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // frame monitor: per-cycle waveform check against the popped expectation
  int   mon_cyc = 0;
  int   frames_done = 0;
  int   spurious = 0;
  int   idle_cnt = 0;
  int   last_gap = 0;
  int   frame_errs = 0;
  int   shifts = 0;
  logic [7:0] rx;
  logic rxp;
  exp_t cur;

  always @(negedge clk) begin
    int k, b;
    logic e;
    if (!reset) begin
      mon_cyc  = 0;
      idle_cnt = 0;
      if (tx_done) spurious++;
    end else begin
      if (mon_cyc != 0) begin
        k = mon_cyc;
        b = (k - 1) / N;
        if (k <= FB * N) begin
          if (b == 0)                  e = 1'b0;
          else if (b <= 8)             e = cur.data[b-1];
          else if (b == 9 && FB == 11) e = cur.par;
          else                         e = 1'b1;
          if (tx !== e || tx_busy !== 1'b1 || tx_done !== 1'b0 || piso_load !== 1'b0)
            frame_errs++;
          if (b >= 1 && b <= 8 && (k - 1) % N == N / 2) rx[b-1] = tx;
          if (b == 9 && (k - 1) % N == N / 2) rxp = tx;
          if (piso_shift) shifts++;
          mon_cyc++;
        end else begin
          check("frame_wave", frame_errs, 0);
          check("rx_byte", rx, cur.data);
`ifdef UART_TX_PARITY_EN
          check("rx_parity", rxp, cur.par);
`endif
          check("shift_count", shifts, 8);
          check("done_pulse", tx_done, 1);
          check("done_idle", {tx_busy, tx}, 2'b01);
          frames_done++;
          mon_cyc  = 0;
          idle_cnt = 0;
        end
      end else if (tx_done) begin
        spurious++;
      end
      if (mon_cyc == 0) begin
        idle_cnt++;
        if (piso_load) begin
          check("sb_pending", sb.size() != 0, 1);
          cur = (sb.size() != 0) ? sb.pop_front() : '0;
          check("load_data", piso_data, cur.data);
          last_gap   = idle_cnt;
          mon_cyc    = 1;
          frame_errs = 0;
          shifts     = 0;
          rx         = 8'h00;
          rxp        = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic p);
    @(posedge clk);
    #1;
    tx_start = 1'b1;
    tx_data  = d;
    sb.push_back({p, d});
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("frame_timeout", frames_done >= target, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    logic found;

    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'hA3, 1'b0};
    vecs[4] = '{8'h07, 1'b1};
    vecs[5] = '{8'h03, 1'b0};
    vecs[6] = '{8'h80, 1'b1};
    vecs[7] = '{8'h01, 1'b1};
    vecs[8] = '{8'h96, 1'b0};

    // reset state, with tx_start already high
    reset    = 1'b0;
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    #2;
    check("reset_tx", tx, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_done", tx_done, 0);
    check("reset_load", piso_load, 0);
    check("reset_shift", piso_shift, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_busy", tx_busy, 0);
    check("reset_hold_load", piso_load, 0);

    // release with tx_start high: first clock accepts
    tx_data = vecs[0].data;
    sb.push_back({vecs[0].par, vecs[0].data});
    reset = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    check("accept_after_reset", tx_busy, 1);
    wait_frames(1);

    for (int i = 1; i < 9; i++) begin
      base = frames_done;
      send(vecs[i].data, vecs[i].par);
      wait_frames(base + 1);
    end

    // request while busy is ignored
    base = frames_done;
    send(8'h00, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    tx_start = 1'b1;
    tx_data  = 8'hFF;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    wait_frames(base + 1);
    repeat (50) @(posedge clk);
    #1;
    check("no_second_frame", frames_done, base + 1);
    check("idle_after_ignore", tx_busy, 0);

    // tx_start held high: back-to-back frames with one idle cycle
    base = frames_done;
    @(posedge clk);
    #1;
    tx_start = 1'b1;
    tx_data  = 8'hA3;
    sb.push_back({1'b0, 8'hA3});
    sb.push_back({1'b0, 8'hA3});
    n = 0;
    while (frames_done < base + 1 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    tx_start = 1'b0;
    check("b2b_first_done", frames_done >= base + 1, 1);
    wait_frames(base + 2);
    check("b2b_gap", last_gap, 1);

    // request in the tx_done cycle
    base = frames_done;
    send(8'h3C, 1'b0);
    n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (tx_done) found = 1'b1;
    end
    check("done_seen", found, 1);
    tx_start = 1'b1;
    tx_data  = 8'hC3;
    sb.push_back({1'b0, 8'hC3});
    #1;
    check("load_in_done_cycle", piso_load, 1);
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    wait_frames(base + 2);
    check("done_cycle_gap", last_gap, 1);

    // reset during the third data bit aborts the frame
    base = frames_done;
    send(8'h5A, 1'b0);
    repeat (13) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", tx_busy, 0);
    check("abort_shift", piso_shift, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("abort_no_done", frames_done, base);
    send(8'h0F, 1'b0);
    wait_frames(base + 1);

    repeat (5) @(posedge clk);
    #1;
    check("spurious_done", spurious, 0);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
